rr_mux_nx1: RTL

Registered N-to-1 multiplexer with built-in arbitration and valid/ready handshakes. It generalises the combinational 2:1 select into a parametrised channel count and data width. Selection is made by an internal round-robin or fixed-priority arbiter rather than an external `sel`. It sits between several producer channels and one consumer, and provides one output register stage with full throughput.

---
 rtl/rr_mux_nx1.sv | 100 ++++++++++
 1 files changed

// File: rtl/rr_mux_nx1.sv
// rr_mux_nx1: registered N-to-1 multiplexer with an internal round-robin or
// fixed-priority arbiter and valid/ready handshakes on both sides.
// One output register stage; a word may be loaded in the same cycle the
// previous one drains, so throughput is one word per cycle.
module rr_mux_nx1 #(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  parameter  int MODE  = 0,
  localparam int SW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_sel,
  input  logic                 out_ready
);

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [SW-1:0]    out_sel_reg;
  logic [SW-1:0]    ptr_reg;
  logic [SW-1:0]    ptr_next;

  logic [SW-1:0]    grant_idx;
  logic             grant_found;
  logic             load;
  int               scan_idx;

  logic [WIDTH-1:0] ch_data [N];

  // The output register can accept a word when empty or draining this cycle;
  // held off entirely while reset is asserted.
  assign load = !rst && (!out_valid_reg || out_ready);

  // Slice the flat input bus per channel and drive the one-hot ready.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi] = load && grant_found && (grant_idx == SW'(gi));
    end
  endgenerate

  // Arbiter: scan from the highest offset down so the nearest valid channel
  // (from ptr in round-robin, from 0 in fixed priority) is the last written.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = 0;
    for (int off = N - 1; off >= 0; off--) begin
      if (MODE == 0) begin
        scan_idx = (int'(ptr_reg) + off) % N;
      end else begin
        scan_idx = off;
      end
      if (in_valid[SW'(scan_idx)]) begin
        grant_idx   = SW'(scan_idx);
        grant_found = 1'b1;
      end
    end
  end

  // Round-robin pointer moves to the channel after the one just granted.
  always_comb begin
    ptr_next = ptr_reg;
    if (MODE == 0) begin
      if (grant_idx == SW'(N - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = grant_idx + 1'b1;
      end
    end
  end

  // Output register and pointer update on input/output transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      ptr_reg       <= '0;
    end else if (load && grant_found) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= ch_data[grant_idx];
      out_sel_reg   <= grant_idx;
      ptr_reg       <= ptr_next;
    end else if (load) begin
      // Drained (or already empty) with nothing to refill: data/sel hold.
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule
